ex2a_seq: RTL

Stimulus sequencer and response capture for the 4-input combinational block `ex2a`. It drives `{a,b,c,d}` through all 16 combinations in ascending order and holds each vector for a programmable number of clock cycles. Before advancing, it samples the block's outputs `f1` and `f2` into two 16-bit truth-table maps. It sits directly upstream of `ex2a`, feeding its inputs and consuming its outputs, so a single `start` pulse produces the complete truth table in hardware.

---
 rtl/ex2a_seq_if.sv | 29 ++
 rtl/ex2a_seq.sv | 95 +++++++++
 2 files changed

// File: rtl/ex2a_seq_if.sv
// Signal bundle between the ex2a stimulus sequencer and its surroundings:
// the run request, the ex2a response, the stimulus vector, status and captured maps.
interface ex2a_seq_if;
  // start is a level request with no ready: the sequencer samples it only in IDLE
  // or DONE and ignores it in DRIVE; f1/f2 are combinational responses to a..d.
  logic        start;
  logic        f1;
  logic        f2;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic [15:0] f1_map;
  logic [15:0] f2_map;
  logic [1:0]  dbg_state;

  modport master (
    input  start, f1, f2,
    output a, b, c, d, vec_idx, busy, done, f1_map, f2_map, dbg_state
  );

  modport slave (
    output start, f1, f2,
    input  a, b, c, d, vec_idx, busy, done, f1_map, f2_map, dbg_state
  );
endinterface

// File: rtl/ex2a_seq.sv
// Sweeps {a,b,c,d} through 0..15, holding each vector DWELL cycles, and captures
// the ex2a responses f1/f2 on the last dwell cycle into two 16-bit truth-table maps.
module ex2a_seq #(
  parameter int unsigned DWELL = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  ex2a_seq_if.master  bus
);

  localparam int unsigned      CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      f1_map_q, f1_map_d;
  logic [15:0]      f2_map_q, f2_map_d;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    f1_map_d = f1_map_q;
    f2_map_d = f2_map_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = DRIVE;
          vec_d    = 4'd0;
          cnt_d    = '0;
          f1_map_d = 16'h0000;
          f2_map_d = 16'h0000;
        end
      end
      DRIVE: begin
        if (cnt_q == LAST) begin
          // Only the last dwell cycle is sampled; earlier cycles are settling time.
          f1_map_d[vec_q] = bus.f1;
          f2_map_d[vec_q] = bus.f2;
          if (vec_q == 4'd15) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + 4'd1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= 4'd0;
      cnt_q    <= '0;
      f1_map_q <= 16'h0000;
      f2_map_q <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      f1_map_q <= f1_map_d;
      f2_map_q <= f2_map_d;
      busy_q   <= (state_d == DRIVE);
      done_q   <= (state_d == DONE);
    end
  end

  // Stimulus bits are taken straight from the index register, so they stay registered.
  assign bus.a         = vec_q[3];
  assign bus.b         = vec_q[2];
  assign bus.c         = vec_q[1];
  assign bus.d         = vec_q[0];
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.f1_map    = f1_map_q;
  assign bus.f2_map    = f2_map_q;
  assign bus.dbg_state = state_q;

endmodule
